reorder_buffer: RTL and testbench

In-order commit engine for the out-of-order core: allocates ROB tags to decoded instructions, collects results from the CDB, and retires them in program order. It is the writer side of the register file's ROB port: it drives the write/tag/data commit bus and the global flush. It also signals store commits to the LSB and redirects fetch on branch mispredict.

---
 rtl/reorder_buffer_pkg.sv | 22 ++
 rtl/reorder_buffer.sv | 167 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: entry type encodings, field widths and tag-increment helper. Rev 1.0
`default_nettype none

package reorder_buffer_pkg;

  localparam int REG_ID_W = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2
  } rob_type_e;

  // Tag 0 means "no tag", so the pointer wraps from max_tag straight back to 1.
  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned max_tag);
    return (tag >= max_tag) ? 32'd1 : tag + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit engine (allocate, collect CDB results, retire, flush). Rev 1.0
// Optional macro ROB_BYPASS_EN: query ports also forward the same-cycle CDB broadcast.
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_LOG = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    from_decoder_valid,
  input  logic [1:0]              from_decoder_type,
  input  logic [REG_ID_W-1:0]     from_decoder_reg_id,
  output logic [ROB_SIZE_LOG-1:0] to_decoder_rob_id,
  output logic                    to_decoder_full,
  input  logic [ROB_SIZE_LOG-1:0] from_decoder_query_a,
  input  logic [ROB_SIZE_LOG-1:0] from_decoder_query_b,
  output logic                    to_decoder_ready_a,
  output logic                    to_decoder_ready_b,
  output logic [DATA_W-1:0]       to_decoder_data_a,
  output logic [DATA_W-1:0]       to_decoder_data_b,
  input  logic                    from_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] from_cdb_rob_id,
  input  logic [DATA_W-1:0]       from_cdb_data,
  input  logic                    from_cdb_mispredict,
  output logic                    to_regfile_write_enabled,
  output logic [REG_ID_W-1:0]     to_regfile_reg_id,
  output logic [DATA_W-1:0]       to_regfile_data,
  output logic [ROB_SIZE_LOG-1:0] to_regfile_rob_id,
  output logic                    to_lsb_store_commit,
  output logic [ROB_SIZE_LOG-1:0] to_lsb_rob_id,
  output logic                    flush_output,
  output logic [DATA_W-1:0]       to_fetch_pc
);

  localparam int DEPTH   = 1 << ROB_SIZE_LOG;
  localparam int MAX_TAG = DEPTH - 1;

  typedef logic [ROB_SIZE_LOG-1:0] tag_t;

  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    ready;
  logic [DEPTH-1:0]    mispredict;
  rob_type_e           type_q [DEPTH];
  logic [REG_ID_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];

  tag_t head;
  tag_t tail;
  tag_t count;

  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;

  // The flush pulse cycle doubles as a decoder stall while the buffer is cleared.
  assign to_decoder_full   = (count == tag_t'(MAX_TAG)) || flush_output;
  assign to_decoder_rob_id = tail;

  assign alloc_fire  = from_decoder_valid && !to_decoder_full;
  assign cdb_fire    = from_cdb_valid && (from_cdb_rob_id != '0) && busy[from_cdb_rob_id];
  assign commit_fire = busy[head] && ready[head] && !flush_output;

  function automatic logic [DATA_W:0] lookup(input tag_t q);
    logic [DATA_W:0] res;
    res = '0;
    if (q != '0) begin
      res = {ready[q], data_q[q]};
`ifdef ROB_BYPASS_EN
      if (from_cdb_valid && (from_cdb_rob_id == q)) begin
        res = {1'b1, from_cdb_data};
      end
`endif
    end
    return res;
  endfunction

  always_comb begin
    {to_decoder_ready_a, to_decoder_data_a} = lookup(from_decoder_query_a);
    {to_decoder_ready_b, to_decoder_data_b} = lookup(from_decoder_query_b);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy       <= '0;
      ready      <= '0;
      mispredict <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= ROB_TYPE_REG;
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
      head                     <= tag_t'(1);
      tail                     <= tag_t'(1);
      count                    <= '0;
      to_regfile_write_enabled <= 1'b0;
      to_regfile_reg_id        <= '0;
      to_regfile_data          <= '0;
      to_regfile_rob_id        <= '0;
      to_lsb_store_commit      <= 1'b0;
      to_lsb_rob_id            <= '0;
      flush_output             <= 1'b0;
      to_fetch_pc              <= '0;
    end else begin
      to_regfile_write_enabled <= 1'b0;
      to_lsb_store_commit      <= 1'b0;
      flush_output             <= 1'b0;

      if (flush_output) begin
        busy  <= '0;
        ready <= '0;
        head  <= tag_t'(1);
        tail  <= tag_t'(1);
        count <= '0;
      end else begin
        if (alloc_fire) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= 1'b0;
          mispredict[tail] <= 1'b0;
          type_q[tail]     <= rob_type_e'(from_decoder_type);
          reg_q[tail]      <= from_decoder_reg_id;
          tail             <= tag_t'(tag_inc(32'(tail), MAX_TAG));
        end

        if (cdb_fire) begin
          ready[from_cdb_rob_id]      <= 1'b1;
          data_q[from_cdb_rob_id]     <= from_cdb_data;
          mispredict[from_cdb_rob_id] <= from_cdb_mispredict;
        end

        if (commit_fire) begin
          busy[head] <= 1'b0;
          head       <= tag_t'(tag_inc(32'(head), MAX_TAG));
          case (type_q[head])
            ROB_TYPE_REG: begin
              to_regfile_write_enabled <= (reg_q[head] != '0);
              to_regfile_reg_id        <= reg_q[head];
              to_regfile_data          <= data_q[head];
              to_regfile_rob_id        <= head;
            end
            ROB_TYPE_STORE: begin
              to_lsb_store_commit <= 1'b1;
              to_lsb_rob_id       <= head;
            end
            ROB_TYPE_BRANCH: begin
              if (mispredict[head]) begin
                flush_output <= 1'b1;
                to_fetch_pc  <= data_q[head];
              end
            end
            default: ;
          endcase
        end

        case ({alloc_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a queue scoreboard checked by an output monitor.
`default_nettype none

module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int L = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dec_valid = 1'b0;
  logic [1:0]    dec_type = 2'd0;
  logic [4:0]    dec_reg = 5'd0;
  logic [L-1:0]  dec_rob_id;
  logic          dec_full;
  logic [L-1:0]  qa = '0, qb = '0;
  logic          rdy_a, rdy_b;
  logic [31:0]   dat_a, dat_b;
  logic          cdb_valid = 1'b0;
  logic [L-1:0]  cdb_tag = '0;
  logic [31:0]   cdb_data = '0;
  logic          cdb_mp = 1'b0;
  logic          rf_we;
  logic [4:0]    rf_reg;
  logic [31:0]   rf_data;
  logic [L-1:0]  rf_tag;
  logic          st_commit;
  logic [L-1:0]  st_tag;
  logic          flush;
  logic [31:0]   fetch_pc;

  reorder_buffer #(.ROB_SIZE_LOG(L)) dut (
    .clk_in(clk), .rst_in(rst),
    .from_decoder_valid(dec_valid), .from_decoder_type(dec_type), .from_decoder_reg_id(dec_reg),
    .to_decoder_rob_id(dec_rob_id), .to_decoder_full(dec_full),
    .from_decoder_query_a(qa), .from_decoder_query_b(qb),
    .to_decoder_ready_a(rdy_a), .to_decoder_ready_b(rdy_b),
    .to_decoder_data_a(dat_a), .to_decoder_data_b(dat_b),
    .from_cdb_valid(cdb_valid), .from_cdb_rob_id(cdb_tag), .from_cdb_data(cdb_data),
    .from_cdb_mispredict(cdb_mp),
    .to_regfile_write_enabled(rf_we), .to_regfile_reg_id(rf_reg), .to_regfile_data(rf_data),
    .to_regfile_rob_id(rf_tag),
    .to_lsb_store_commit(st_commit), .to_lsb_rob_id(st_tag),
    .flush_output(flush), .to_fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 reg write, 1 store, 2 flush
    logic [4:0]  reg_id;
    logic [31:0] data;
    logic [2:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   commit_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observable commit-side pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (rf_we || st_commit || flush)) begin
      exp_t act, e;
      if (flush)          act = '{kind: 2'd2, reg_id: 5'd0, data: fetch_pc, tag: 3'd0};
      else if (st_commit) act = '{kind: 2'd1, reg_id: 5'd0, data: 32'd0, tag: st_tag};
      else                act = '{kind: 2'd0, reg_id: rf_reg, data: rf_data, tag: rf_tag};
      if (act.kind == 2'd0) commit_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 64'(act), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("commit_event", 64'(act), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic alloc(input rob_type_e t, input logic [4:0] r);
    dec_valid = 1'b1; dec_type = t; dec_reg = r;
    tick();
    dec_valid = 1'b0;
  endtask

  task automatic cdb(input logic [L-1:0] t, input logic [31:0] d, input logic mp);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d; cdb_mp = mp;
    tick();
    cdb_valid = 1'b0; cdb_mp = 1'b0;
  endtask

  task automatic exp_reg(input logic [4:0] r, input logic [31:0] d, input logic [2:0] t);
    exp_q.push_back('{kind: 2'd0, reg_id: r, data: d, tag: t});
  endtask

  task automatic exp_store(input logic [2:0] t);
    exp_q.push_back('{kind: 2'd1, reg_id: 5'd0, data: 32'd0, tag: t});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_rob_id", 64'(dec_rob_id), 64'd1);
    check("rst_full", 64'(dec_full), 64'd0);
    check("rst_pulses", 64'({rf_we, st_commit, flush}), 64'd0);
    check("rst_data", 64'({rf_data, fetch_pc}), 64'd0);
    check("rst_ids", 64'({rf_reg, rf_tag, st_tag}), 64'd0);

    // Basic register commit
    alloc(ROB_TYPE_REG, 5'd5);
    check("alloc_rob_id", 64'(dec_rob_id), 64'd2);
    exp_reg(5'd5, 32'hDEADBEEF, 3'd1);
    cdb(3'd1, 32'hDEADBEEF, 1'b0);
    idle(3);

    // x0 destination commits silently, then head moves on to tag 3
    alloc(ROB_TYPE_REG, 5'd0);
    cdb(3'd2, 32'h55, 1'b0);
    alloc(ROB_TYPE_REG, 5'd7);
    exp_reg(5'd7, 32'h1234, 3'd3);
    cdb(3'd3, 32'h1234, 1'b0);
    idle(3);

    // Out-of-order completion retires in program order on consecutive cycles
    alloc(ROB_TYPE_REG, 5'd1);
    alloc(ROB_TYPE_REG, 5'd2);
    alloc(ROB_TYPE_REG, 5'd3);
    exp_reg(5'd1, 32'h11, 3'd4);
    exp_reg(5'd2, 32'h22, 3'd5);
    exp_reg(5'd3, 32'h33, 3'd6);
    cdb(3'd6, 32'h33, 1'b0);
    cdb(3'd5, 32'h22, 1'b0);
    cdb(3'd4, 32'h11, 1'b0);
    idle(5);
    if (commit_cyc.size() >= 5) begin
      check("inorder_gap_1", 64'(commit_cyc[3] - commit_cyc[2]), 64'd1);
      check("inorder_gap_2", 64'(commit_cyc[4] - commit_cyc[3]), 64'd1);
    end else begin
      check("inorder_commits", 64'(commit_cyc.size()), 64'd5);
    end

    // Reset with an entry in flight: nothing commits, late CDB ignored
    alloc(ROB_TYPE_REG, 5'd9);
    do_reset();
    check("midrst_rob_id", 64'(dec_rob_id), 64'd1);
    cdb(3'd1, 32'hBAD, 1'b0);
    idle(3);

    // Fill to capacity with stores
    for (int i = 0; i < 7; i++) alloc(ROB_TYPE_STORE, 5'd0);
    check("full_set", 64'(dec_full), 64'd1);
    check("full_rob_id_wrap", 64'(dec_rob_id), 64'd1);
    alloc(ROB_TYPE_REG, 5'd3);
    check("full_blocks_alloc", 64'({dec_full, dec_rob_id}), 64'({1'b1, 3'd1}));
    exp_store(3'd1);
    cdb(3'd1, 32'd0, 1'b0);
    tick();
    check("full_clear_after_commit", 64'(dec_full), 64'd0);
    for (int t = 2; t <= 7; t++) begin
      exp_store(3'(t));
      cdb(3'(t), 32'd0, 1'b0);
    end
    idle(4);

    // Mispredicted branch flushes the younger, already-complete entry
    alloc(ROB_TYPE_BRANCH, 5'd0);
    alloc(ROB_TYPE_REG, 5'd4);
    cdb(3'd2, 32'h99, 1'b0);
    exp_q.push_back('{kind: 2'd2, reg_id: 5'd0, data: 32'h100, tag: 3'd0});
    cdb(3'd1, 32'h100, 1'b1);
    tick();
    check("flush_pulse", 64'({flush, fetch_pc}), 64'({1'b1, 32'h100}));
    check("flush_stall", 64'(dec_full), 64'd1);
    tick();
    check("post_flush", 64'({flush, dec_full, dec_rob_id}), 64'({1'b0, 1'b0, 3'd1}));

    // Operand query, with and without same-cycle forwarding
    alloc(ROB_TYPE_REG, 5'd6);
    alloc(ROB_TYPE_REG, 5'd8);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'd7; qa = 3'd2; qb = 3'd0;
    #1;
`ifdef ROB_BYPASS_EN
    check("query_bypass", 64'({rdy_a, dat_a}), 64'({1'b1, 32'd7}));
`else
    check("query_no_bypass", 64'(rdy_a), 64'd0);
`endif
    check("query_tag0", 64'({rdy_b, dat_b}), 64'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    check("query_stored", 64'({rdy_a, dat_a}), 64'({1'b1, 32'd7}));
    exp_reg(5'd6, 32'h66, 3'd1);
    exp_reg(5'd8, 32'd7, 3'd2);
    cdb(3'd1, 32'h66, 1'b0);
    idle(5);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
